spi_ram_arbiter: RTL and testbench
==================================

# spi_ram_arbiter

Two-port arbiter and transaction sequencer for the shared external SPI RAM on the uio pins. It accepts single-byte read/write requests from two requesters: port 0 is the CPU core and port 1 is the test/debug loader. It grants them round-robin and runs one complete SPI mode-0 frame per grant. It sits between the requesters and the uio SPI pins (CS, MOSI, MISO, SCK) and is the only block that drives them.

## Interface
- CLK_DIV, 2: clk cycles per SCK half-period; legal range ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high with fields stable until ack0.
- we0  in  1  port 0 transaction type: 1 = write, 0 = read.
- addr0  in  16  port 0 byte address.
- wdata0  in  8  port 0 write data.
- ack0  out  1  one-cycle pulse when port 0 transaction completes.
- req1, we1, addr1, wdata1, ack1: same as port 0, for port 1.
- rdata  out  8  read data from the most recent completed read, either port.
- grant  out  1  port owning the current or last transaction.
- busy  out  1  high from grant until the DONE cycle inclusive.
- spi_cs_n  out  1  RAM chip select, active low.
- spi_sck  out  1  SPI clock; idles low.
- spi_mosi  out  1  serial data to RAM.
- spi_miso  in  1  serial data from RAM.

## Operation
- Frame: 32 bits, MSB first.
  - cmd byte: 0x03 for read, 0x02 for write.
  - addr[15:8], then addr[7:0].
  - Data byte: wdata on a write, 0x00 on a read.
- Mode 0: MOSI changes only while SCK is low; MISO is sampled on every SCK rising edge into an 8-bit shift register.
- States:
  - IDLE: cs_n=1, sck=0, mosi=0. Arbitrates when any req is high. Latches we/addr/wdata of the winner into a 32-bit shift register and sets grant. Goes to SETUP.
  - SETUP: CLK_DIV cycles; cs_n=0, sck=0, mosi=frame bit 31.
  - SHIFT: 64 half-periods of CLK_DIV cycles each. SCK toggles at the start of each half-period, starting high. The shift register advances one bit on each falling edge. A 6-bit half-period counter ends the phase after the 32nd falling edge.
  - HOLD: CLK_DIV cycles; cs_n=0, sck=0.
  - DONE: 1 cycle; cs_n=1, ack of the granted port =1. On a read, rdata is loaded with the last 8 sampled MISO bits. Goes to IDLE.
- Arbitration:
  - The last_grant register resets to 1, so port 0 wins the first simultaneous request.
  - With both req high in IDLE, the port != last_grant wins. With one req high, that port wins.
  - No starvation: with both ports continuously requesting, grants alternate strictly.
- Requester rule: ack is a 1-cycle pulse. A req still high in the cycle after ack is a new transaction and must carry new fields.
- Writes do not modify rdata. rdata holds its value between reads.

## Timing
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, ack0=ack1=0, rdata=0x00, grant=0, busy=0, state=IDLE, last_grant=1.
- Reset is asynchronous. Outputs take their reset values immediately, including mid-frame.
- A frame cut by reset gives no ack and is not resumed. A req still pending after reset release restarts from IDLE.
- Latency: a req sampled high in IDLE at cycle T gives cs_n=0 at T+1 and the ack pulse at T+1+66·CLK_DIV.
  - CLK_DIV=2 gives ack at T+133.
  - CLK_DIV=1 gives ack at T+67.
- Each frame has exactly 32 SCK rising edges.
- cs_n is high for at least 2 cycles between frames (DONE + IDLE).
- Frame period: 2 + 66·CLK_DIV cycles per back-to-back transaction.
- busy=1 from T+1 through DONE.
- Requests are ignored outside IDLE. A request arriving during another port's frame waits, and its fields must stay stable.

## Test plan
- Port 0 read, addr 0x1234, CLK_DIV=2, MISO model returns 0xA5 -> MOSI 0x03,0x12,0x34,0x00; 32 SCK rises; ack0 pulse at T+133; rdata=0xA5; ack1 stays 0.
- Port 1 write, addr 0x00FF, wdata 0x5A -> MOSI 0x0200FF5A; ack1 pulse only; grant=1; rdata unchanged.
- req0 and req1 raised together after reset -> port 0 served first, then port 1; cs_n high exactly 2 cycles between frames.
- Port 0 requests back-to-back while port 1 holds a request -> grants alternate 0,1,0,1; each ack matches its port.
- rst asserted mid-SHIFT -> same cycle cs_n=1, sck=0, mosi=0; no ack; after release, the held req0 restarts a full frame with ack at T'+1+66·CLK_DIV.
- CLK_DIV=1 read -> SCK toggles every cycle; ack at T+67; rdata correct.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Round-robin arbiter and SPI mode-0 frame sequencer for the shared external SPI RAM.
//   Port 0 is the CPU core, port 1 the test/debug loader. Each grant runs one 32-bit frame:
//   {cmd, addr[15:8], addr[7:0], data}, MSB first, cmd 0x03 = read, 0x02 = write.
//
// Ports
//   clk, rst                      system clock, asynchronous active-high reset
//   req/we/addr/wdata 0 and 1     request: held with stable fields until the matching ack
//   ack0, ack1                    one-cycle completion pulse for the granted port
//   rdata                         data from the most recent completed read (either port)
//   grant                         port owning the current or last transaction
//   busy                          high from the first frame cycle through DONE
//   spi_cs_n, spi_sck, spi_mosi   SPI outputs to the RAM (this block is the only driver)
//   spi_miso                      SPI input from the RAM

module spi_ram_arbiter #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [15:0] addr0,
   input  logic [7:0]  wdata0,
   output logic        ack0,
   input  logic        req1,
   input  logic        we1,
   input  logic [15:0] addr1,
   input  logic [7:0]  wdata1,
   output logic        ack1,
   output logic [7:0]  rdata,
   output logic        grant,
   output logic        busy,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShift,
      StHold,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [5:0]      half_q, half_d;
   logic            sck_q, sck_d;
   logic [31:0]     frame_q, frame_d;
   logic [7:0]      miso_q, miso_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            we_q, we_d;
   logic            grant_q, grant_d;
   logic            last_q, last_d;

   logic            div_end;
   logic            win;
   logic            sel_we;
   logic [15:0]     sel_addr;
   logic [7:0]      sel_wdata;

   assign div_end   = (div_q == DivLast);
   // Both requesting: the port that did not win last time. Otherwise whichever is requesting.
   assign win       = (req0 && req1) ? ~last_q : req1;
   assign sel_we    = win ? we1 : we0;
   assign sel_addr  = win ? addr1 : addr0;
   assign sel_wdata = win ? wdata1 : wdata0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         half_q  <= '0;
         sck_q   <= 1'b0;
         frame_q <= '0;
         miso_q  <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         half_q  <= half_d;
         sck_q   <= sck_d;
         frame_q <= frame_d;
         miso_q  <= miso_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      half_d  = half_q;
      sck_d   = sck_q;
      frame_d = frame_q;
      miso_d  = miso_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      grant_d = grant_q;
      last_d  = last_q;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               grant_d = win;
               last_d  = win;
               we_d    = sel_we;
               frame_d = {sel_we ? 8'h02 : 8'h03, sel_addr, sel_we ? sel_wdata : 8'h00};
               div_d   = '0;
               state_d = StSetup;
            end
         end

         StSetup: begin
            if (div_end) begin
               // First half-period starts with SCK high: that is the first rising edge.
               div_d   = '0;
               half_d  = '0;
               sck_d   = 1'b1;
               miso_d  = {miso_q[6:0], spi_miso};
               state_d = StShift;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end

         StShift: begin
            if (div_end) begin
               div_d = '0;
               if (half_q == 6'd63) begin
                  // Half-period 63 is the low phase after the 32nd falling edge.
                  sck_d   = 1'b0;
                  state_d = StHold;
               end else begin
                  half_d = half_q + 6'd1;
                  sck_d  = ~sck_q;
                  if (sck_q) begin
                     frame_d = {frame_q[30:0], 1'b0};
                  end else begin
                     miso_d = {miso_q[6:0], spi_miso};
                  end
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end

         StHold: begin
            if (div_end) begin
               div_d = '0;
               // Loaded as DONE is entered so rdata is already valid alongside the ack pulse.
               if (!we_q) begin
                  rdata_d = miso_q;
               end
               state_d = StDone;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign spi_cs_n = (state_q == StIdle) || (state_q == StDone);
   assign spi_sck  = sck_q;
   assign spi_mosi = ((state_q == StSetup) || (state_q == StShift)) ? frame_q[31] : 1'b0;
   assign ack0     = (state_q == StDone) && !grant_q;
   assign ack1     = (state_q == StDone) && grant_q;
   assign rdata    = rdata_q;
   assign grant    = grant_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Testbench for spi_ram_arbiter: two instances (CLK_DIV = 1 and 2), each with an SPI RAM model,
// randomized requesters and a scoreboard of pending transactions checked at every ack.

module tb_spi_ram_arbiter;
   timeunit 1ns;
   timeprecision 1ps;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int Dv = gi + 1;
      localparam int FrameLen = 2 + 66 * Dv;

      logic        rst;
      logic [1:0]  req;
      logic [1:0]  we;
      logic [15:0] addr [2];
      logic [7:0]  wdata [2];
      logic [1:0]  ack;
      logic [7:0]  rdata;
      logic        grant, busy, cs_n, sck, mosi;
      logic        miso = 1'b0;
      logic        fin = 1'b0;

      spi_ram_arbiter #(.CLK_DIV(Dv)) u_dut (
         .clk     (clk),
         .rst     (rst),
         .req0    (req[0]),
         .we0     (we[0]),
         .addr0   (addr[0]),
         .wdata0  (wdata[0]),
         .ack0    (ack[0]),
         .req1    (req[1]),
         .we1     (we[1]),
         .addr1   (addr[1]),
         .wdata1  (wdata[1]),
         .ack1    (ack[1]),
         .rdata   (rdata),
         .grant   (grant),
         .busy    (busy),
         .spi_cs_n(cs_n),
         .spi_sck (sck),
         .spi_mosi(mosi),
         .spi_miso(miso)
      );

      // ---------------- SPI RAM model ----------------
      logic [7:0]  ram_mem [65536];
      logic [7:0]  ref_mem [65536];
      int          ram_rises = 0;
      logic [31:0] ram_sr = '0;
      logic [7:0]  ram_cmd = '0;
      logic [15:0] ram_addr = '0;

      always @(negedge cs_n) begin
         ram_rises = 0;
         ram_sr    = '0;
      end

      always @(posedge sck) begin
         if (!cs_n) begin
            ram_sr = {ram_sr[30:0], mosi};
            ram_rises++;
            if (ram_rises == 24) begin
               ram_cmd  = ram_sr[23:16];
               ram_addr = ram_sr[15:0];
            end
         end
      end

      // Drive the next bit after each falling edge; noise outside the data byte of a read.
      always @(negedge sck or negedge cs_n) begin
         if (ram_rises >= 24 && ram_rises < 32 && ram_cmd == 8'h03)
            miso = ram_mem[ram_addr][31 - ram_rises];
         else
            miso = 1'($urandom);
      end

      always @(posedge cs_n) begin
         if (ram_rises == 32 && ram_sr[31:24] == 8'h02) ram_mem[ram_sr[23:8]] = ram_sr[7:0];
      end

      // ---------------- scoreboard ----------------
      txn_t q0[$];
      txn_t q1[$];

      task automatic issue(input int p, input logic w, input logic [15:0] a, input logic [7:0] d);
         txn_t t;
         t.we    = w;
         t.addr  = a;
         t.wdata = d;
         if (w) begin
            ref_mem[a]  = d;
            t.exp_rdata = 8'h00;
         end else begin
            t.exp_rdata = ref_mem[a];
         end
         if (p == 0) q0.push_back(t);
         else q1.push_back(t);
         we[p]    = w;
         addr[p]  = a;
         wdata[p] = d;
         req[p]   = 1'b1;
      endtask

      task automatic wait_ack(input int p);
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!ack[p] && n < 3 * FrameLen + 20);
         if (!ack[p]) chk($sformatf("ack_timeout_div%0d_port%0d", Dv, p), 32'(ack[p]), 32'd1);
         @(posedge clk);
         #1;
      endtask

      task automatic run_port(input int p, input int n);
         for (int k = 0; k < n; k++) begin
            int g;
            g = $urandom_range(0, 2);
            if (g > 0) begin
               req[p] = 1'b0;
               repeat (g) @(posedge clk);
               #1;
            end
            issue(p, 1'($urandom_range(0, 1)),
                  16'h4000 | 16'($urandom_range(0, 7) << 1) | 16'(p), 8'($urandom));
            wait_ack(p);
         end
         req[p] = 1'b0;
      endtask

      // ---------------- monitor ----------------
      logic        in_frame = 1'b0;
      logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
      logic        mlast = 1'b1, mw, ap, fast = 1'b0;
      logic [1:0]  req_prev = 2'b00;
      logic [7:0]  model_rdata = 8'h00;
      logic [31:0] cap, exp_frame;
      int          gap = 100, frame_start = 0, rises = 0;
      txn_t        mt;

      always @(negedge clk) begin
         if (rst) begin
            in_frame    = 1'b0;
            mlast       = 1'b1;
            gap         = 100;
            fast        = 1'b0;
            model_rdata = 8'h00;
         end else begin
            if (cs_n) begin
               gap++;
               if (gap == 2) fast = (req != 2'b00);
               chk("idle_pins_low", 32'({sck, mosi}), 32'd0);
               if (in_frame && !prev_cs) begin
                  chk("frame_bits", cap, exp_frame);
                  chk("sck_rises", 32'(rises), 32'd32);
                  in_frame = 1'b0;
               end
            end else begin
               if (prev_cs) begin
                  if (fast) chk("cs_gap_b2b", 32'(gap), 32'd2);
                  else chk("cs_gap_ge3", 32'(gap > 2), 32'd1);
                  mw = (req_prev == 2'b11) ? ~mlast : req_prev[1];
                  chk("grant_at_start", 32'(grant), 32'(mw));
                  chk("busy_at_start", 32'(busy), 32'd1);
                  mlast = mw;
                  if ((mw ? q1.size() : q0.size()) == 0) begin
                     chk("start_has_pending", 32'(mw ? q1.size() : q0.size()), 32'd1);
                     exp_frame = '0;
                  end else begin
                     mt = mw ? q1[0] : q0[0];
                     exp_frame = {mt.we ? 8'h02 : 8'h03, mt.addr, mt.we ? mt.wdata : 8'h00};
                  end
                  in_frame    = 1'b1;
                  frame_start = cyc;
                  rises       = 0;
                  cap         = '0;
               end
               gap = 0;
            end
            if (in_frame && sck && !prev_sck) begin
               cap = {cap[30:0], mosi};
               rises++;
            end
            if (sck) chk("mosi_stable_sck_high", 32'(mosi), 32'(prev_mosi));
            if (ack != 2'b00) begin
               chk("ack_not_both", 32'(ack == 2'b11), 32'd0);
               ap = ack[1];
               chk("ack_owner", 32'(ap), 32'(mlast));
               chk("ack_grant", 32'(grant), 32'(ap));
               chk("ack_latency", 32'(cyc - frame_start), 32'(66 * Dv));
               chk("ack_cs_high", 32'(cs_n), 32'd1);
               if ((ap ? q1.size() : q0.size()) == 0) begin
                  chk("ack_has_pending", 32'(ap ? q1.size() : q0.size()), 32'd1);
               end else begin
                  mt = ap ? q1.pop_front() : q0.pop_front();
                  if (mt.we) begin
                     chk("rdata_kept_on_write", 32'(rdata), 32'(model_rdata));
                  end else begin
                     chk("rdata_read", 32'(rdata), 32'(mt.exp_rdata));
                     model_rdata = mt.exp_rdata;
                  end
               end
            end
         end
         prev_cs   = cs_n;
         prev_sck  = sck;
         prev_mosi = mosi;
         req_prev  = req;
      end

      // ---------------- stimulus ----------------
      initial begin
         rst      = 1'b1;
         req      = 2'b00;
         we       = 2'b00;
         addr[0]  = '0;
         addr[1]  = '0;
         wdata[0] = '0;
         wdata[1] = '0;
         for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
         end
         ram_mem[16'h1234] = 8'hA5;
         ref_mem[16'h1234] = 8'hA5;

         repeat (3) @(posedge clk);
         @(negedge clk);
         chk("reset_pins", 32'({cs_n, sck, mosi}), 32'b100);
         chk("reset_status", 32'({ack, grant, busy}), 32'd0);
         chk("reset_rdata", 32'(rdata), 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;

         // Simultaneous requests right after reset: port 0 read, then port 1 write.
         issue(0, 1'b0, 16'h1234, 8'h00);
         issue(1, 1'b1, 16'h00FF, 8'h5A);
         fork
            begin wait_ack(0); req[0] = 1'b0; end
            begin wait_ack(1); req[1] = 1'b0; end
         join

         // Random traffic from both ports, including back-to-back contention.
         fork
            run_port(0, 6);
            run_port(1, 6);
         join
         repeat (4) @(posedge clk);
         #1;

         // Reset in the middle of SHIFT, then the held request restarts.
         issue(0, 1'b0, 16'h0010, 8'h00);
         for (int n = 0; n < 10 && cs_n; n++) @(negedge clk);
         repeat (Dv + 10) @(posedge clk);
         #3;
         rst = 1'b1;
         #1;
         chk("midframe_reset_pins", 32'({cs_n, sck, mosi}), 32'b100);
         chk("midframe_reset_status", 32'({ack, busy, grant}), 32'd0);
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         wait_ack(0);
         req[0] = 1'b0;

         repeat (5) @(posedge clk);
         chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
         fin = 1'b1;
      end
   end

   initial begin
      wait (g_inst[0].fin && g_inst[1].fin);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule
